// File: rtl/bios_boot_loader_pkg.sv
// Shared types and constants for the bios boot-time copy sequencer.
package bios_boot_loader_pkg;

  localparam int BIOS_ADDR_W = 18;
  localparam int BIOS_DATA_W = 16;

  localparam logic [1:0] ROM_BE_WORD = 2'b11;
  localparam logic [1:0] ROM_BE_LOW  = 2'b01;

  typedef enum logic [1:0] {
    START = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } boot_state_e;

endpackage

// File: rtl/bios_boot_loader.sv
// Boot-time sequencer: holds the CPU, copies WORDS ROM words into RAM,
// sums them into a 16-bit checksum, then releases the CPU.
//
// RAM write handshake: ram_we is the valid. While ram_we is high, ram_addr
// and ram_wdata are held stable; the word is transferred on the rising edge
// where ram_we and ram_ack are both high. ram_ack with ram_we low is ignored.
module bios_boot_loader
  import bios_boot_loader_pkg::*;
#(
  parameter int                     WORDS    = 4096,
  parameter logic [BIOS_ADDR_W-1:0] SRC_BASE = 18'h00000,
  parameter logic [BIOS_ADDR_W-1:0] DST_BASE = 18'h00000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   restart,
  output logic [BIOS_ADDR_W-1:0] rom_addr,
  output logic [1:0]             rom_be,
  output logic                   rom_ce,
  input  logic [BIOS_DATA_W-1:0] rom_data,
  output logic [BIOS_ADDR_W-1:0] ram_addr,
  output logic [BIOS_DATA_W-1:0] ram_wdata,
  output logic                   ram_we,
  input  logic                   ram_ack,
  output logic                   cpu_hold,
  output logic                   done,
  output logic [BIOS_DATA_W-1:0] checksum
);

  localparam int             CNT_W = $clog2(WORDS) + 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WORDS - 1);

  boot_state_e             state, state_nxt;
  logic [CNT_W-1:0]        count;
  logic [BIOS_DATA_W-1:0]  wbuf;
  logic [BIOS_DATA_W-1:0]  sum;

  // State register; reset aborts any copy in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= START;
    else        state <= state_nxt;
  end

  // Next-state decode: one READ then one or more WRITE cycles per word.
  always_comb begin
    state_nxt = state;
    case (state)
      START:   state_nxt = READ;
      READ:    state_nxt = WRITE;
      WRITE:   if (ram_ack) state_nxt = (count == LAST) ? DONE : READ;
      DONE:    if (restart) state_nxt = START;
      default: state_nxt = START;
    endcase
  end

  // Word counter, read buffer and running checksum (carry out is dropped).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      wbuf  <= '0;
      sum   <= '0;
    end else begin
      case (state)
        START: begin
          count <= '0;
          sum   <= '0;
        end
        READ:  wbuf <= rom_data;
        WRITE: if (ram_ack) begin
          sum <= sum + wbuf;
          if (count != LAST) count <= count + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Output decode from registered state, count and wbuf only.
  always_comb begin
    rom_be    = ROM_BE_WORD;
    rom_ce    = (state == READ);
    ram_we    = (state == WRITE);
    cpu_hold  = (state != DONE);
    done      = (state == DONE);
    rom_addr  = SRC_BASE + BIOS_ADDR_W'(count);
    ram_addr  = DST_BASE + BIOS_ADDR_W'(count);
    ram_wdata = wbuf;
    checksum  = sum;
  end

endmodule
